// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: state encoding,
// baud divisor arithmetic and frame-shape helpers.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_t;

  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;

  // Clocks per bit, truncated toward zero.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Frame length in bit periods, start through last stop bit.
  function automatic int frame_bits(input int parity_en, input int stop_bits);
    return START_BITS + DATA_BITS + ((parity_en != 0) ? 1 : 0) + stop_bits;
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 and flags the last count of each period.
// Shared between the UART transmitter and receiver.
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] count_r;
  logic          tick_r;

  // Counter plus a registered tick that is high exactly while count_r == LAST.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (clear) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else if (count_r == LAST) begin
      count_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
      tick_r  <= ((count_r + {{(CW-1){1'b0}}, 1'b1}) == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_sender.sv
// UART transmitter: accepts a byte on TX_EN while idle and serialises it as
// start, D0..D7, optional parity and 1 or 2 stop bits on a registered line.
module uart_sender
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int   DIV       = calc_div(CLK_FREQ, BAUD);
  localparam logic USE_PAR   = (PARITY_EN != 0);
  localparam logic ODD_PAR   = (PARITY_ODD != 0);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  if (DIV < 2) begin : g_bad_div
    $error("uart_sender: CLK_FREQ/BAUD must be at least 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_sender: STOP_BITS must be 1 or 2");
  end

  uart_state_t state_r;
  logic [2:0]  bit_idx_r;
  logic        stop_cnt_r;
  logic [7:0]  shift_r;
  logic        tx_line_r;
  logic        tx_status_r;
  logic        clear_s;
  logic        tick_s;

  // Hold the bit timer at zero while idle so every frame starts a fresh period.
  assign clear_s = (state_r == S_IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (clear_s),
    .tick   (tick_s)
  );

  // Frame sequencer; the byte register is only written on accept.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      bit_idx_r   <= 3'd0;
      stop_cnt_r  <= 1'b0;
      shift_r     <= 8'h00;
      tx_line_r   <= 1'b1;
      tx_status_r <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (TX_EN) begin
            shift_r     <= TX_DATA;
            state_r     <= S_START;
            bit_idx_r   <= 3'd0;
            tx_line_r   <= 1'b0;
            tx_status_r <= 1'b0;
          end else begin
            tx_line_r   <= 1'b1;
            tx_status_r <= 1'b1;
          end
        end
        S_START: begin
          if (tick_s) begin
            state_r   <= S_DATA;
            bit_idx_r <= 3'd0;
            tx_line_r <= shift_r[0];
          end
        end
        S_DATA: begin
          if (tick_s) begin
            if (bit_idx_r == 3'd7) begin
              if (USE_PAR) begin
                state_r   <= S_PARITY;
                tx_line_r <= calc_parity(shift_r, ODD_PAR);
              end else begin
                state_r    <= S_STOP;
                stop_cnt_r <= 1'b0;
                tx_line_r  <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_line_r <= shift_r[bit_idx_r + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (tick_s) begin
            state_r    <= S_STOP;
            stop_cnt_r <= 1'b0;
            tx_line_r  <= 1'b1;
          end
        end
        S_STOP: begin
          if (tick_s) begin
            if (stop_cnt_r == LAST_STOP) begin
              state_r     <= S_IDLE;
              tx_status_r <= 1'b1;
            end else begin
              stop_cnt_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= S_IDLE;
          tx_line_r   <= 1'b1;
          tx_status_r <= 1'b1;
        end
      endcase
    end
  end

  assign UART_TX   = tx_line_r;
  assign TX_STATUS = tx_status_r;

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: four configurations driven in parallel, checked every
// cycle against a frame-timing model plus hand-computed expectations.
module tb_uart_sender;

  localparam int DIV = 16;
  localparam int PE_M [4] = '{0, 1, 1, 0};
  localparam int PO_M [4] = '{0, 0, 1, 0};
  localparam int ST_M [4] = '{1, 1, 1, 2};

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_en   = 1'b0;
  logic [3:0] line_s;
  logic [3:0] status_s;

  int compared   = 0;
  int mismatched = 0;

  always #5 sysclk = ~sysclk;

  uart_sender #(.CLK_FREQ(1600), .BAUD(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .sysclk(sysclk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(status_s[0]), .UART_TX(line_s[0]));
  uart_sender #(.CLK_FREQ(1600), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .sysclk(sysclk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(status_s[1]), .UART_TX(line_s[1]));
  uart_sender #(.CLK_FREQ(1600), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .sysclk(sysclk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(status_s[2]), .UART_TX(line_s[2]));
  uart_sender #(.CLK_FREQ(1600), .BAUD(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d (
    .sysclk(sysclk), .reset(reset), .TX_DATA(tx_data), .TX_EN(tx_en),
    .TX_STATUS(status_s[3]), .UART_TX(line_s[3]));

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line level n bit periods into a frame carrying byte d.
  function automatic logic model_bit(input int n, input logic [7:0] d, input int pe, input int po);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if ((pe != 0) && (n == 9)) return (po != 0) ? ~^d : ^d;
    return 1'b1;
  endfunction

  function automatic int frame_cycles(input int i);
    return (1 + 8 + PE_M[i] + ST_M[i]) * DIV;
  endfunction

  // Reference model: per-instance "busy since edge k with byte d".
  logic        m_busy [4];
  longint      m_start[4];
  logic [7:0]  m_data [4];
  longint      edge_n = 0;

  initial begin
    logic en_v, r_v, exp_line;
    logic [7:0] d_v;
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0; m_start[i] = 0; m_data[i] = 8'h00;
    end
    forever begin
      @(posedge sysclk);
      en_v = tx_en; d_v = tx_data; r_v = reset;
      edge_n++;
      for (int i = 0; i < 4; i++) begin
        if (r_v) m_busy[i] = 1'b0;
        else if (m_busy[i] && (edge_n - m_start[i] == longint'(frame_cycles(i)))) m_busy[i] = 1'b0;
        else if (!m_busy[i] && en_v) begin
          m_busy[i] = 1'b1; m_start[i] = edge_n; m_data[i] = d_v;
        end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_line = m_busy[i] ? model_bit(int'((edge_n - m_start[i]) / DIV), m_data[i], PE_M[i], PO_M[i]) : 1'b1;
        chk($sformatf("model_line[%0d]", i), int'(line_s[i]), int'(exp_line));
        chk($sformatf("model_status[%0d]", i), int'(status_s[i]), int'(!m_busy[i]));
      end
    end
  end

  task automatic step();
    @(posedge sysclk);
    #2;
  endtask

  task automatic wait_all_idle();
    int n = 0;
    while (status_s != 4'hF && n < 2000) begin
      step();
      n++;
    end
    chk("idle_wait", int'(status_s), 15);
  endtask

  // Send one byte, watch instance idx: busy length and mid-bit samples.
  task automatic run_frame(input logic [7:0] d, input int idx, input int inj_at,
                           output int busy, output logic [9:0] bits);
    wait_all_idle();
    tx_data = d;
    tx_en   = 1'b1;
    step();
    tx_en = 1'b0;
    busy  = 0;
    bits  = 10'h000;
    while (status_s[idx] == 1'b0 && busy < 1000) begin
      if ((busy % DIV == DIV / 2) && (busy < 10 * DIV)) bits[busy / DIV] = line_s[idx];
      if (busy == inj_at) begin
        tx_en = 1'b1; tx_data = 8'hFF;
      end else begin
        tx_en = 1'b0;
      end
      busy++;
      step();
    end
    tx_en = 1'b0;
  endtask

  initial begin
    int busy, n, hi;
    logic [9:0] bits;

    repeat (3) step();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (line_s == 4'hF && status_s == 4'hF) n++;
      step();
    end
    chk("idle_hold", n, 100);

    run_frame(8'h55, 0, -1, busy, bits);
    chk("busy_55", busy, 160);
    chk("bits_55", int'(bits), 10'h2AA);

    run_frame(8'h07, 1, -1, busy, bits);
    chk("busy_even_par", busy, 176);
    chk("even_parity_bit", int'(bits[9]), 1);
    run_frame(8'h07, 2, -1, busy, bits);
    chk("busy_odd_par", busy, 176);
    chk("odd_parity_bit", int'(bits[9]), 0);

    run_frame(8'hA3, 0, 40, busy, bits);
    chk("busy_A3", busy, 160);
    chk("bits_A3", int'(bits), 10'h346);
    repeat (20) step();
    chk("no_second_frame", int'(status_s[0]), 1);

    wait_all_idle();
    tx_data = 8'h00;
    tx_en   = 1'b1;
    step();
    n = 0;
    while (status_s[3] == 1'b0 && n < 1000) begin n++; step(); end
    chk("stop2_busy_1", n, 176);
    hi = 0;
    while (status_s[3] == 1'b1 && hi < 100) begin hi++; step(); end
    chk("stop2_gap", hi, 1);
    n = 0;
    while (status_s[3] == 1'b0 && n < 1000) begin n++; step(); end
    chk("stop2_busy_2", n, 176);
    tx_en = 1'b0;

    wait_all_idle();
    tx_data = 8'h00;
    tx_en   = 1'b1;
    step();
    tx_en = 1'b0;
    repeat (70) step();
    reset = 1'b1;
    #1;
    chk("async_reset_line", int'(line_s), 15);
    chk("async_reset_status", int'(status_s), 15);
    step();
    step();
    reset = 1'b0;
    run_frame(8'h81, 0, -1, busy, bits);
    chk("busy_81", busy, 160);
    chk("bits_81", int'(bits), 10'h302);

    for (int i = 0; i < 1500; i++) begin
      tx_en   = ($urandom_range(0, 15) == 0);
      tx_data = 8'($urandom);
      reset   = ($urandom_range(0, 499) == 0);
      step();
    end
    tx_en = 1'b0;
    reset = 1'b0;
    wait_all_idle();
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
